// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline hazard/stall/flush controller with MDU and memory wait FSM
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_redirect,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_flush,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MDU_WAIT = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       freeze;
  logic       load_use;

  assign freeze   = mem_req && !dmem_ready;
  assign load_use = ex_valid && ex_mem_read && (ex_rd_addr != 5'd0) &&
                    ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                     (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      stall_cycles <= '0;
    end else begin
      state_q <= state_d;
      if (pc_stall)
        stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // MEM_WAIT behaves like RUN once memory responds, so both share one branch
  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_WAIT: begin
        if (!freeze && mdu_done)
          state_d = RUN;
      end
      default: begin
        if (freeze)
          state_d = MEM_WAIT;
        else if (!ex_redirect && ex_mdu_start)
          state_d = MDU_WAIT;
        else
          state_d = RUN;
      end
    endcase
  end

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    if (!rst_n) begin
      pc_stall = 1'b0;
    end else if (freeze) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else begin
      case (state_q)
        MDU_WAIT: begin
          if (!mdu_done) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
          end
        end
        default: begin
          if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (ex_mdu_start) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_rs1_used, id_rs2_used, ex_valid, ex_mem_read;
  logic        ex_redirect, ex_mdu_start, mdu_done, mem_req, dmem_ready;

  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush;
  logic [1:0]  state_o;
  logic [31:0] stall_cycles;

  logic        s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall, s_id_ex_flush, s_ex_mem_stall, s_ex_mem_flush;
  logic [1:0]  s_state_o;
  logic [2:0]  s_stall_cycles;

  always #5 clk = ~clk;

  pipeline_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .state_o(state_o), .stall_cycles(stall_cycles)
  );

  // Narrow counter instance exercises the wrap from 7 back to 0
  pipeline_ctrl #(.CNT_W(3)) u_small (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall), .if_id_flush(s_if_id_flush),
    .id_ex_stall(s_id_ex_stall), .id_ex_flush(s_id_ex_flush),
    .ex_mem_stall(s_ex_mem_stall), .ex_mem_flush(s_ex_mem_flush),
    .state_o(s_state_o), .stall_cycles(s_stall_cycles)
  );

  typedef struct {
    string       name;
    logic [6:0]  ctl;
    logic [1:0]  st;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  // ctl order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_FRZ  = 7'b1101010;
  localparam logic [6:0] C_RED  = 7'b0010100;
  localparam logic [6:0] C_MDU  = 7'b1101001;
  localparam logic [6:0] C_LU   = 7'b1100100;

  task automatic cmp(input string name, input string what, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s %s: actual %h required %h", name, what, act, req);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [6:0] ctl, sctl;
      e    = q.pop_front();
      ctl  = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush};
      sctl = {s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall, s_id_ex_flush, s_ex_mem_stall, s_ex_mem_flush};
      cmp(e.name, "ctl", {25'd0, ctl}, {25'd0, e.ctl});
      cmp(e.name, "state", {30'd0, state_o}, {30'd0, e.st});
      cmp(e.name, "stall_cycles", stall_cycles, e.cnt);
      cmp(e.name, "small_ctl", {25'd0, sctl}, {25'd0, e.ctl});
      cmp(e.name, "small_state", {30'd0, s_state_o}, {30'd0, e.st});
      cmp(e.name, "small_cnt", {29'd0, s_stall_cycles}, {29'd0, e.cnt[2:0]});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
    ex_redirect = 1'b0; ex_mdu_start = 1'b0; mdu_done = 1'b0;
    mem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [6:0] ctl, input logic [1:0] st, input logic [31:0] cnt);
    exp_t e;
    e.name = name; e.ctl = ctl; e.st = st; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = rd;
    id_rs2_used = 1'b1; id_rs2_addr = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
    ex_redirect = 1'b0; ex_mdu_start = 1'b0; mdu_done = 1'b0;
    mem_req = 1'b1; dmem_ready = 1'b0;

    next_cycle(); rst_n = 1'b0; mem_req = 1'b1;            expect_out("reset", C_NONE, 2'd0, 0);
    next_cycle();                                          expect_out("idle0", C_NONE, 2'd0, 0);
    next_cycle(); set_load_use(5'd5);                      expect_out("lu_rs2", C_LU, 2'd0, 0);
    next_cycle();                                          expect_out("lu_after", C_NONE, 2'd0, 1);
    next_cycle(); set_load_use(5'd0);                      expect_out("lu_x0", C_NONE, 2'd0, 1);
    next_cycle(); set_load_use(5'd7); id_rs2_used = 1'b0;
                  id_rs1_addr = 5'd7;                      expect_out("lu_unused", C_NONE, 2'd0, 1);
    next_cycle(); set_load_use(5'd9); ex_valid = 1'b0;     expect_out("lu_invalid", C_NONE, 2'd0, 1);
    next_cycle(); set_load_use(5'd3); id_rs2_used = 1'b0;
                  id_rs1_used = 1'b1; id_rs1_addr = 5'd3;  expect_out("lu_rs1", C_LU, 2'd0, 1);
    next_cycle(); set_load_use(5'd5); ex_redirect = 1'b1;  expect_out("red_lu", C_RED, 2'd0, 2);
    next_cycle();                                          expect_out("red_lu_after", C_NONE, 2'd0, 2);
    next_cycle(); ex_redirect = 1'b1; ex_mdu_start = 1'b1; expect_out("red_mdu", C_RED, 2'd0, 2);
    next_cycle();                                          expect_out("red_mdu_after", C_NONE, 2'd0, 2);

    next_cycle(); ex_mdu_start = 1'b1;                     expect_out("mdu_c0", C_MDU, 2'd0, 2);
    next_cycle();                                          expect_out("mdu_c1", C_MDU, 2'd1, 3);
    next_cycle();                                          expect_out("mdu_c2", C_MDU, 2'd1, 4);
    next_cycle();                                          expect_out("mdu_c3", C_MDU, 2'd1, 5);
    next_cycle(); mdu_done = 1'b1;                         expect_out("mdu_c4", C_NONE, 2'd1, 6);
    next_cycle(); mdu_done = 1'b1;                         expect_out("mdu_c5", C_NONE, 2'd0, 6);

    next_cycle(); mem_req = 1'b1;                          expect_out("mem_c0", C_FRZ, 2'd0, 6);
    next_cycle(); mem_req = 1'b1;                          expect_out("mem_c1", C_FRZ, 2'd2, 7);
    next_cycle(); mem_req = 1'b1;                          expect_out("mem_c2", C_FRZ, 2'd2, 8);
    next_cycle(); mem_req = 1'b1; dmem_ready = 1'b1;       expect_out("mem_c3", C_NONE, 2'd2, 9);
    next_cycle();                                          expect_out("mem_c4", C_NONE, 2'd0, 9);

    next_cycle(); ex_mdu_start = 1'b1;                     expect_out("mdufrz_c0", C_MDU, 2'd0, 9);
    next_cycle(); mdu_done = 1'b1; mem_req = 1'b1;         expect_out("mdufrz_c1", C_FRZ, 2'd1, 10);
    next_cycle(); mdu_done = 1'b1;                         expect_out("mdufrz_c2", C_NONE, 2'd1, 11);
    next_cycle(); mdu_done = 1'b1;                         expect_out("mdufrz_c3", C_NONE, 2'd0, 11);

    next_cycle(); mem_req = 1'b1;                          expect_out("memlu_c0", C_FRZ, 2'd0, 11);
    next_cycle(); mem_req = 1'b1; dmem_ready = 1'b1;
                  set_load_use(5'd12);                     expect_out("memlu_c1", C_LU, 2'd2, 12);
    next_cycle();                                          expect_out("memlu_c2", C_NONE, 2'd0, 13);

    next_cycle(); ex_mdu_start = 1'b1;                     expect_out("rstmdu_c0", C_MDU, 2'd0, 13);
    next_cycle(); rst_n = 1'b0;                            expect_out("rstmdu_c1", C_NONE, 2'd1, 14);
    next_cycle();                                          expect_out("rstmdu_c2", C_NONE, 2'd0, 0);

    next_cycle(); mem_req = 1'b1;                          expect_out("rstmem_c0", C_FRZ, 2'd0, 0);
    next_cycle(); rst_n = 1'b0; mem_req = 1'b1;            expect_out("rstmem_c1", C_NONE, 2'd2, 1);
    next_cycle();                                          expect_out("rstmem_c2", C_NONE, 2'd0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: actual %0d pending required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
